// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path and its control unit.
package mips_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

    // Instruction field slices
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/mips_next_pc.sv
// Next-PC select for the held instruction: jump beats taken branch beats fall-through.
module mips_next_pc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] next_pc
);

    logic [15:0] imm;
    logic [25:0] target;

    assign imm    = instr[IMM_MSB:IMM_LSB];
    assign target = instr[TARGET_MSB:TARGET_LSB];

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], target, 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack and hands the word
// to decode over valid/ready, redirecting on the accept edge.
//
// state   | meaning
// S_IDLE  | just out of reset, no request yet
// S_FETCH | imem_req high at pc, waiting for imem_ack
// S_HOLD  | instruction held and valid, waiting for instr_ready
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] retired
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  retired_q;
    logic         req_q;
    logic         valid_q;
    logic [31:0]  next_pc_d;

    mips_next_pc u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .next_pc  (next_pc_d)
    );

    // req/valid are registered alongside the state so the handshakes are glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            retired_q <= 32'h0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= S_HOLD;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        pc_q      <= next_pc_d;
                        retired_q <= retired_q + 32'd1;
                        state_q   <= S_FETCH;
                        req_q     <= 1'b1;
                        valid_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign imm         = instr_q[IMM_MSB:IMM_LSB];
    assign pc_plus4    = pc_q + 32'd4;
    assign retired     = retired_q;

endmodule
